// File: rtl/vmem_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : vmem_arbiter
// Description : Shares the single-port video memory between the VGA scan-out
//               read path and one buffered pixel-write requester. Scan-out
//               reads own the memory while vga_valid=1. Writes wait in a small
//               FIFO and are drained in order during blanking.
// Ports       : clk, rst (async, active-high)
//               vga_valid, h_addr, v_addr -> vga_data    scan-out side
//               wr_valid, wr_addr, wr_data -> wr_ready   write requester
//               mem_addr, mem_we, mem_wdata <- mem_rdata memory side
//               fifo_count, wr_pending                   buffer status
//               steal_cnt                                (VMEM_ARB_STEAL_EN only)
// Options     : VMEM_ARB_STEAL_EN - when the FIFO is full during active video,
//               steal at most one pixel slot per 16 clocks to drain one entry.
// Revision    : 1.0 - initial release
//==============================================================================
module vmem_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        vga_valid,
    input  logic [9:0]                  h_addr,
    input  logic [8:0]                  v_addr,
    output logic [DATA_W-1:0]           vga_data,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_we,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        wr_pending
`ifdef VMEM_ARB_STEAL_EN
    ,
    output logic [15:0]                 steal_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [0:0] c_ST_READ  = 1'b0;
    localparam logic [0:0] c_ST_DRAIN = 1'b1;

    // Write buffer storage and pointers
    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              r_wr_ready;
    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_vga_data;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_steal;
    logic              w_write;
    logic [ADDR_W-1:0] w_scan_addr;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_FULL_CNT);
    assign w_push      = wr_valid && r_wr_ready;
    assign w_scan_addr = ADDR_W'({h_addr, v_addr});

    // A write happens in any blanking cycle with buffered data, so the very
    // first blanking cycle already drains the head entry.
    assign w_write = (!vga_valid && !w_empty) || w_steal;
    assign w_pop   = w_write;

`ifdef VMEM_ARB_STEAL_EN
    logic [3:0]  r_gap;
    logic [15:0] r_steal_cnt;

    // r_gap counts clocks since the last steal and saturates at 15, so the
    // next steal is allowed no earlier than 16 clocks after the previous one.
    assign w_steal   = vga_valid && w_full && (r_gap == 4'hF);
    assign steal_cnt = r_steal_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap       <= 4'hF;
            r_steal_cnt <= '0;
        end else if (w_steal) begin
            r_gap <= '0;
            if (r_steal_cnt != 16'hFFFF) begin
                r_steal_cnt <= r_steal_cnt + 16'd1;
            end
        end else if (r_gap != 4'hF) begin
            r_gap <= r_gap + 4'd1;
        end
    end
`else
    assign w_steal = 1'b0;
`endif

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= wr_addr;
            r_fifo_data[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wr_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count    <= w_count_next;
            // Tracks the registered count, so a full FIFO refuses a push even
            // when an entry pops in the same cycle.
            r_wr_ready <= (w_count_next != c_FULL_CNT);
        end
    end

    // Arbitration state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_READ;
        end else begin
            case (r_state)
                c_ST_READ: begin
                    if (!vga_valid && !w_empty) begin
                        r_state <= c_ST_DRAIN;
                    end
                end
                c_ST_DRAIN: begin
                    if (vga_valid || w_empty) begin
                        r_state <= c_ST_READ;
                    end
                end
                default: r_state <= c_ST_READ;
            endcase
        end
    end

    // Scan-out pixel register; a stolen slot repeats the previous pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vga_data <= '0;
        end else if (!w_steal) begin
            r_vga_data <= vga_valid ? mem_rdata : '0;
        end
    end

    // Memory port mux; held at zero while reset is asserted.
    always_comb begin
        mem_addr  = w_scan_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (rst) begin
            mem_addr = '0;
        end else if (w_write) begin
            mem_addr  = r_fifo_addr[r_rd_ptr];
            mem_we    = 1'b1;
            mem_wdata = r_fifo_data[r_rd_ptr];
        end
    end

    assign vga_data   = r_vga_data;
    assign wr_ready   = r_wr_ready;
    assign fifo_count = r_count;
    assign wr_pending = (r_count != '0);

endmodule
`default_nettype wire
